nf10_output_distributor: RTL and testbench
==========================================

Name: nf10_output_distributor

Overview:
One-to-N AXI4-Stream packet distributor; the transmit-side counterpart of the input arbiter.
- Takes the single merged stream after the output-port lookup.
- Steers each packet to one or more of 5 output streams, using the one-hot destination field in tuser; multicast is supported.
- Each output has a one-beat registered slot, so outputs drain independently.
- Packets with an empty destination mask are consumed and counted as drops.

Parameters:
C_M_AXIS_DATA_WIDTH, 256, tdata width of every output stream
C_S_AXIS_DATA_WIDTH, 256, tdata width of the input stream; must equal C_M_AXIS_DATA_WIDTH
C_M_AXIS_TUSER_WIDTH, 128, tuser width of every output stream
C_S_AXIS_TUSER_WIDTH, 128, tuser width of the input stream; must equal C_M_AXIS_TUSER_WIDTH
C_NUM_PORTS, 5, number of output streams, fixed at 5 in this revision
C_DST_POS, 24, bit index of the destination-mask LSB in tuser; output i is selected by tuser[C_DST_POS+i]

Ports:
axi_aclk  in  1  clock
axi_resetn  in  1  asynchronous active-low reset
s_axis_tdata  in  256  input data
s_axis_tstrb  in  32  input byte strobes
s_axis_tuser  in  128  input sideband; destination mask at [C_DST_POS+4:C_DST_POS]
s_axis_tvalid  in  1  input valid
s_axis_tready  out  1  input ready
s_axis_tlast  in  1  input end of packet
m_axis_tdata_i  out  256  output i data (i = 0..4)
m_axis_tstrb_i  out  32  output i strobes
m_axis_tuser_i  out  128  output i sideband, passed through unmodified
m_axis_tvalid_i  out  1  output i valid
m_axis_tready_i  in  1  output i ready
m_axis_tlast_i  out  1  output i end of packet
drop_count  out  32  number of packets with an empty mask; saturates at 0xFFFFFFFF

Behaviour:
- Reset: one clock, axi_aclk. axi_resetn is asynchronous and active-low.
  - While reset is asserted: all m_axis_tvalid_i = 0, s_axis_tready = 0, drop_count = 0, state = HEAD, slots empty.
  - Data, strb, user and last registers are don't-care in reset.
- Reset mid-packet: the in-flight packet is lost. After release the block restarts in HEAD, and the next input beat is treated as a packet head.
- Slot i holds pend[i] plus one beat. m_axis_tvalid_i = pend[i] (registered). Valid never depends on ready.
- Slot i is free when (!pend[i] | m_axis_tready_i).
- s_axis_tready = AND over i in active mask of (slot i free). When the active mask is zero, s_axis_tready = 1.
  - It is combinational from m_axis_tready_i. This is allowed, since ready may depend on ready.
- Active mask:
  - In state HEAD, the active mask is s_axis_tuser[C_DST_POS+4:C_DST_POS].
  - In state BODY, it is the mask latched at the head beat.
  - tuser on non-head beats is ignored for steering.
- FSM:
  - HEAD: on an accepted beat with tlast = 0, latch the mask and go to BODY. On tlast = 1 (single-beat packet), stay in HEAD.
  - BODY: on an accepted beat with tlast = 1, go to HEAD.
- Accepted beat (s_axis_tvalid & s_axis_tready):
  - Every slot i in the active mask loads the beat and sets pend[i] = 1.
  - A slot i not in the active mask that handshakes this cycle clears pend[i].
- Latency: 1 cycle from input acceptance to m_axis_tvalid_i.
- Throughput: 1 beat/cycle when all selected outputs are ready.
- Multicast: all selected outputs advance in lock-step per input beat but drain independently. A stalled output stalls the input only for packets that include it.
- Simultaneous drain and load on a slot: the slot reloads with the new beat and pend stays 1.
- Drop: if the head-beat mask is zero, every beat of the packet is accepted with tready = 1 and discarded.
  - drop_count increments by 1 when the head beat is accepted, saturating.
- Mask bits above C_NUM_PORTS are ignored.
- tstrb, tuser and tlast travel with the beat unmodified.

Decomposition:
- Package nf10_distributor_pkg holds:
  - constants C_DST_POS and C_NUM_PORTS;
  - state encoding HEAD/BODY;
  - a localparam for the mask width.
- Sub-module nf10_axis_out_slot: a one-beat register slot.
  - Inputs: load, beat.
  - Outputs: m_axis_* for one port.
  - Also outputs its "free" flag.
  - The top level instantiates it 5 times via generate.

Test Plan:
- Unicast: 3-beat packet, mask 0b00100, m_axis_tready_2 held 1 -> beats appear on output 2 only, one cycle after each input handshake; tlast on beat 3; other valids stay 0.
- Multicast backpressure: mask 0b10001, m_axis_tready_4 = 0 for 4 cycles -> output 0 receives beat 1, then s_axis_tready = 0 until ready_4 rises; both outputs deliver identical data; no beat is duplicated or lost.
- Independent port: port 3 stalled holding a beat; next packet has mask 0b00010 -> input continues at 1 beat/cycle to output 1, unaffected by port 3.
- Drop: 2-beat packet, mask 0 -> s_axis_tready = 1 for both beats, no output valid, drop_count goes 0 -> 1; preset the counter to 0xFFFFFFFF and drop again -> it stays 0xFFFFFFFF.
- Steering latch: 4-beat packet with head mask 0b01000 and random tuser on later beats -> all 4 beats go to output 3.
- Reset mid-packet: assert axi_resetn = 0 during beat 2 of 4 -> all valids drop immediately (asynchronous); after release the next beat is treated as a head and steered by its own mask.

Source files
------------

// File: rtl/nf10_distributor_pkg.sv
// Shared constants for the transmit-side packet distributor: port count,
// destination-mask position in tuser and the packet-framing FSM encoding.
package nf10_distributor_pkg;

    localparam int C_NUM_PORTS = 5;
    localparam int C_DST_POS   = 24;
    localparam int MASK_W      = C_NUM_PORTS;

    localparam logic [0:0] ST_HEAD = 1'b0;
    localparam logic [0:0] ST_BODY = 1'b1;

    typedef logic [MASK_W-1:0] dst_mask_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/nf10_axis_out_slot.sv
// One-beat registered AXI4-Stream output slot. Valid is purely registered;
// a load on the same cycle as a drain refills the slot without a bubble.
module nf10_axis_out_slot #(
    parameter int DATA_W = 256,
    parameter int USER_W = 128
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic [DATA_W-1:0]   in_tdata,
    input  logic [DATA_W/8-1:0] in_tstrb,
    input  logic [USER_W-1:0]   in_tuser,
    input  logic                in_tlast,
    output logic [DATA_W-1:0]   m_axis_tdata,
    output logic [DATA_W/8-1:0] m_axis_tstrb,
    output logic [USER_W-1:0]   m_axis_tuser,
    output logic                m_axis_tvalid,
    input  logic                m_axis_tready,
    output logic                m_axis_tlast,
    output logic                free
);

    logic pend;

    assign m_axis_tvalid = pend;
    assign free          = !pend | m_axis_tready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend <= 1'b0;
        end else if (load) begin
            pend <= 1'b1;
        end else if (m_axis_tready) begin
            pend <= 1'b0;
        end
    end

    // Payload needs no reset: it is only observed while pend is set.
    always_ff @(posedge clk) begin
        if (load) begin
            m_axis_tdata <= in_tdata;
            m_axis_tstrb <= in_tstrb;
            m_axis_tuser <= in_tuser;
            m_axis_tlast <= in_tlast;
        end
    end

endmodule

// File: rtl/nf10_output_distributor.sv
// One-to-five AXI4-Stream packet distributor steered by the one-hot
// destination mask in the head beat's tuser; empty-mask packets are dropped.
module nf10_output_distributor #(
    parameter int C_M_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_M_AXIS_TUSER_WIDTH = 128,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int C_NUM_PORTS          = 5,
    parameter int C_DST_POS            = 24
) (
    input  logic                              axi_aclk,
    input  logic                              axi_resetn,

    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic                              s_axis_tvalid,
    output logic                              s_axis_tready,
    input  logic                              s_axis_tlast,

    output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata_0,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb_0,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser_0,
    output logic                              m_axis_tvalid_0,
    input  logic                              m_axis_tready_0,
    output logic                              m_axis_tlast_0,

    output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata_1,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb_1,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser_1,
    output logic                              m_axis_tvalid_1,
    input  logic                              m_axis_tready_1,
    output logic                              m_axis_tlast_1,

    output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata_2,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb_2,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser_2,
    output logic                              m_axis_tvalid_2,
    input  logic                              m_axis_tready_2,
    output logic                              m_axis_tlast_2,

    output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata_3,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb_3,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser_3,
    output logic                              m_axis_tvalid_3,
    input  logic                              m_axis_tready_3,
    output logic                              m_axis_tlast_3,

    output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata_4,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb_4,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser_4,
    output logic                              m_axis_tvalid_4,
    input  logic                              m_axis_tready_4,
    output logic                              m_axis_tlast_4,

    output logic [31:0]                       drop_count
);

    import nf10_distributor_pkg::*;

    localparam int DW = C_M_AXIS_DATA_WIDTH;
    localparam int UW = C_M_AXIS_TUSER_WIDTH;

    logic [0:0]             state;
    logic [C_NUM_PORTS-1:0] mask_q;
    logic [C_NUM_PORTS-1:0] active_mask;
    logic [C_NUM_PORTS-1:0] free;
    logic [C_NUM_PORTS-1:0] load;
    logic [C_NUM_PORTS-1:0] m_ready;
    logic [C_NUM_PORTS-1:0] m_valid;
    logic [C_NUM_PORTS-1:0] m_last;
    logic [C_NUM_PORTS-1:0][DW-1:0]   m_data;
    logic [C_NUM_PORTS-1:0][DW/8-1:0] m_strb;
    logic [C_NUM_PORTS-1:0][UW-1:0]   m_user;
    logic                   accept;
    logic [31:0]            drop_cnt;

    // Steering comes from the live tuser only on the head beat.
    assign active_mask = (state == ST_HEAD) ? s_axis_tuser[C_DST_POS +: C_NUM_PORTS] : mask_q;

    // Unselected ports never hold the input back; an empty mask accepts freely.
    assign s_axis_tready = axi_resetn & (&(free | ~active_mask));
    assign accept        = s_axis_tvalid & s_axis_tready;
    assign load          = {C_NUM_PORTS{accept}} & active_mask;

    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            state    <= ST_HEAD;
            mask_q   <= '0;
            drop_cnt <= '0;
        end else if (accept) begin
            if (state == ST_HEAD) begin
                if (!s_axis_tlast) begin
                    state  <= ST_BODY;
                    mask_q <= active_mask;
                end
                if (active_mask == '0) begin
                    drop_cnt <= sat_inc(drop_cnt);
                end
            end else if (s_axis_tlast) begin
                state <= ST_HEAD;
            end
        end
    end

    assign drop_count = drop_cnt;

    assign m_ready = {m_axis_tready_4, m_axis_tready_3, m_axis_tready_2,
                      m_axis_tready_1, m_axis_tready_0};

    for (genvar i = 0; i < C_NUM_PORTS; i++) begin : g_slot
        nf10_axis_out_slot #(
            .DATA_W (DW),
            .USER_W (UW)
        ) u_slot (
            .clk           (axi_aclk),
            .rst_n         (axi_resetn),
            .load          (load[i]),
            .in_tdata      (s_axis_tdata),
            .in_tstrb      (s_axis_tstrb),
            .in_tuser      (s_axis_tuser),
            .in_tlast      (s_axis_tlast),
            .m_axis_tdata  (m_data[i]),
            .m_axis_tstrb  (m_strb[i]),
            .m_axis_tuser  (m_user[i]),
            .m_axis_tvalid (m_valid[i]),
            .m_axis_tready (m_ready[i]),
            .m_axis_tlast  (m_last[i]),
            .free          (free[i])
        );
    end

    assign m_axis_tdata_0  = m_data[0];
    assign m_axis_tstrb_0  = m_strb[0];
    assign m_axis_tuser_0  = m_user[0];
    assign m_axis_tvalid_0 = m_valid[0];
    assign m_axis_tlast_0  = m_last[0];

    assign m_axis_tdata_1  = m_data[1];
    assign m_axis_tstrb_1  = m_strb[1];
    assign m_axis_tuser_1  = m_user[1];
    assign m_axis_tvalid_1 = m_valid[1];
    assign m_axis_tlast_1  = m_last[1];

    assign m_axis_tdata_2  = m_data[2];
    assign m_axis_tstrb_2  = m_strb[2];
    assign m_axis_tuser_2  = m_user[2];
    assign m_axis_tvalid_2 = m_valid[2];
    assign m_axis_tlast_2  = m_last[2];

    assign m_axis_tdata_3  = m_data[3];
    assign m_axis_tstrb_3  = m_strb[3];
    assign m_axis_tuser_3  = m_user[3];
    assign m_axis_tvalid_3 = m_valid[3];
    assign m_axis_tlast_3  = m_last[3];

    assign m_axis_tdata_4  = m_data[4];
    assign m_axis_tstrb_4  = m_strb[4];
    assign m_axis_tuser_4  = m_user[4];
    assign m_axis_tvalid_4 = m_valid[4];
    assign m_axis_tlast_4  = m_last[4];

endmodule

// File: tb/tb_nf10_output_distributor.sv
// Directed bench for the output distributor: unicast, multicast backpressure,
// port independence, drops with saturation, steering latch and mid-packet reset.
module tb_nf10_output_distributor;

    logic         axi_aclk;
    logic         axi_resetn;
    logic [255:0] s_axis_tdata;
    logic [31:0]  s_axis_tstrb;
    logic [127:0] s_axis_tuser;
    logic         s_axis_tvalid;
    logic         s_axis_tready;
    logic         s_axis_tlast;
    logic [4:0]   oready;
    logic [4:0]   ovalid;
    logic [4:0]   olast;
    logic [255:0] odata [5];
    logic [31:0]  ostrb [5];
    logic [127:0] ouser [5];
    logic [31:0]  drop_count;

    int n_checks = 0;
    int n_fail   = 0;
    int ocnt [5] = '{default: 0};

    nf10_output_distributor dut (
        .axi_aclk        (axi_aclk),
        .axi_resetn      (axi_resetn),
        .s_axis_tdata    (s_axis_tdata),
        .s_axis_tstrb    (s_axis_tstrb),
        .s_axis_tuser    (s_axis_tuser),
        .s_axis_tvalid   (s_axis_tvalid),
        .s_axis_tready   (s_axis_tready),
        .s_axis_tlast    (s_axis_tlast),
        .m_axis_tdata_0  (odata[0]), .m_axis_tstrb_0 (ostrb[0]), .m_axis_tuser_0 (ouser[0]),
        .m_axis_tvalid_0 (ovalid[0]), .m_axis_tready_0 (oready[0]), .m_axis_tlast_0 (olast[0]),
        .m_axis_tdata_1  (odata[1]), .m_axis_tstrb_1 (ostrb[1]), .m_axis_tuser_1 (ouser[1]),
        .m_axis_tvalid_1 (ovalid[1]), .m_axis_tready_1 (oready[1]), .m_axis_tlast_1 (olast[1]),
        .m_axis_tdata_2  (odata[2]), .m_axis_tstrb_2 (ostrb[2]), .m_axis_tuser_2 (ouser[2]),
        .m_axis_tvalid_2 (ovalid[2]), .m_axis_tready_2 (oready[2]), .m_axis_tlast_2 (olast[2]),
        .m_axis_tdata_3  (odata[3]), .m_axis_tstrb_3 (ostrb[3]), .m_axis_tuser_3 (ouser[3]),
        .m_axis_tvalid_3 (ovalid[3]), .m_axis_tready_3 (oready[3]), .m_axis_tlast_3 (olast[3]),
        .m_axis_tdata_4  (odata[4]), .m_axis_tstrb_4 (ostrb[4]), .m_axis_tuser_4 (ouser[4]),
        .m_axis_tvalid_4 (ovalid[4]), .m_axis_tready_4 (oready[4]), .m_axis_tlast_4 (olast[4]),
        .drop_count      (drop_count)
    );

    initial begin
        axi_aclk = 1'b0;
        forever #5 axi_aclk = ~axi_aclk;
    end

    // Output-side handshake counter, used to catch duplicated or lost beats.
    always @(posedge axi_aclk) begin
        for (int i = 0; i < 5; i++)
            if (ovalid[i] && oready[i]) ocnt[i] <= ocnt[i] + 1;
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] mk_user(input logic [4:0] m, input logic [127:0] junk);
        logic [127:0] u;
        u = junk;
        u[28:24] = m;
        return u;
    endfunction

    function automatic logic [31:0] strb_of(input logic [255:0] d);
        return d[31:0] ^ 32'h5A5A_5A5A;
    endfunction

    // Presents one beat from a negedge and returns at the negedge after it is
    // accepted; waits reports how many cycles the input was stalled.
    task automatic send(input logic [255:0] d, input logic [127:0] u, input logic l,
                        output int waits);
        s_axis_tdata  = d;
        s_axis_tstrb  = strb_of(d);
        s_axis_tuser  = u;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        waits = 0;
        #1;
        while (!s_axis_tready && waits < 50) begin
            @(negedge axi_aclk);
            waits++;
            #1;
        end
        if (waits >= 50) check("send_timeout", 256'(waits), 256'd0);
        @(negedge axi_aclk);
        s_axis_tvalid = 1'b0;
    endtask

    task automatic expect_beat(input string tag, input logic [4:0] vmask, input int p,
                               input logic [255:0] d, input logic l);
        check({tag, "/valid"}, 256'(ovalid), 256'(vmask));
        check({tag, "/data"},  odata[p], d);
        check({tag, "/strb"},  256'(ostrb[p]), 256'(strb_of(d)));
        check({tag, "/last"},  256'(olast[p]), 256'(l));
    endtask

    initial begin
        int w;
        int c0, c4;
        logic [127:0] u;

        axi_resetn    = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tstrb  = '0;
        s_axis_tuser  = '0;
        s_axis_tlast  = 1'b0;
        s_axis_tvalid = 1'b0;
        oready        = 5'b11111;

        #2;
        check("rst/valid", 256'(ovalid), 256'd0);
        check("rst/tready", 256'(s_axis_tready), 256'd0);
        check("rst/drop", 256'(drop_count), 256'd0);
        repeat (2) @(negedge axi_aclk);
        axi_resetn = 1'b1;

        // Unicast to port 2; bit above the mask field must be ignored.
        u = mk_user(5'b00100, 128'h0) | (128'h1 << 29);
        send(256'hA1, u, 1'b0, w);
        check("uni/wait1", 256'(w), 256'd0);
        expect_beat("uni1", 5'b00100, 2, 256'hA1, 1'b0);
        check("uni1/user", 256'(ouser[2]), 256'(u));
        send(256'hA2, u, 1'b0, w);
        expect_beat("uni2", 5'b00100, 2, 256'hA2, 1'b0);
        send(256'hA3, u, 1'b1, w);
        expect_beat("uni3", 5'b00100, 2, 256'hA3, 1'b1);
        @(negedge axi_aclk);
        check("uni/idle", 256'(ovalid), 256'd0);

        // Multicast 0+4 with port 4 stalled.
        c0 = ocnt[0];
        c4 = ocnt[4];
        oready[4] = 1'b0;
        send(256'hB1, mk_user(5'b10001, 128'h0), 1'b0, w);
        expect_beat("mc1", 5'b10001, 0, 256'hB1, 1'b0);
        check("mc1/data4", odata[4], 256'hB1);
        s_axis_tdata  = 256'hB2;
        s_axis_tstrb  = strb_of(256'hB2);
        s_axis_tuser  = mk_user(5'b00010, 128'h0);
        s_axis_tlast  = 1'b1;
        s_axis_tvalid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("mc/stall_tready", 256'(s_axis_tready), 256'd0);
            check("mc/stall_data4", odata[4], 256'hB1);
            @(negedge axi_aclk);
            check("mc/stall_valid", 256'(ovalid), 256'(5'b10000));
        end
        oready[4] = 1'b1;
        #1;
        check("mc/release_tready", 256'(s_axis_tready), 256'd1);
        @(negedge axi_aclk);
        s_axis_tvalid = 1'b0;
        expect_beat("mc2", 5'b10001, 0, 256'hB2, 1'b1);
        expect_beat("mc2p4", 5'b10001, 4, 256'hB2, 1'b1);
        @(negedge axi_aclk);
        check("mc/idle", 256'(ovalid), 256'd0);
        check("mc/cnt0", 256'(ocnt[0] - c0), 256'd2);
        check("mc/cnt4", 256'(ocnt[4] - c4), 256'd2);

        // Port 3 stalled with a beat; port-1 traffic must flow unhindered.
        oready[3] = 1'b0;
        send(256'hC0, mk_user(5'b01000, 128'h0), 1'b1, w);
        expect_beat("ind0", 5'b01000, 3, 256'hC0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            send(256'hC1 + 256'(k), mk_user(5'b00010, 128'h0), (k == 2), w);
            check("ind/wait", 256'(w), 256'd0);
            expect_beat("ind", 5'b01010, 1, 256'hC1 + 256'(k), (k == 2));
        end
        check("ind/hold3", odata[3], 256'hC0);
        oready[3] = 1'b1;
        @(negedge axi_aclk);
        check("ind/idle", 256'(ovalid), 256'd0);

        // Drop: empty mask; later-beat tuser is ignored.
        send(256'hD1, mk_user(5'b00000, 128'h0), 1'b0, w);
        check("drop/wait1", 256'(w), 256'd0);
        check("drop1/valid", 256'(ovalid), 256'd0);
        check("drop1/cnt", 256'(drop_count), 256'd1);
        send(256'hD2, mk_user(5'b11111, 128'h0), 1'b1, w);
        check("drop/wait2", 256'(w), 256'd0);
        check("drop2/valid", 256'(ovalid), 256'd0);
        check("drop2/cnt", 256'(drop_count), 256'd1);
        force dut.drop_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.drop_cnt;
        @(negedge axi_aclk);
        check("drop/preset", 256'(drop_count), 256'hFFFF_FFFF);
        send(256'hD3, mk_user(5'b00000, 128'h0), 1'b1, w);
        check("drop/sat", 256'(drop_count), 256'hFFFF_FFFF);
        check("drop3/valid", 256'(ovalid), 256'd0);

        // Steering is latched from the head beat.
        send(256'hE1, mk_user(5'b01000, 128'h0), 1'b0, w);
        expect_beat("latch1", 5'b01000, 3, 256'hE1, 1'b0);
        send(256'hE2, mk_user(5'b00111, {$urandom, $urandom, $urandom, $urandom}), 1'b0, w);
        expect_beat("latch2", 5'b01000, 3, 256'hE2, 1'b0);
        send(256'hE3, mk_user(5'b10000, {$urandom, $urandom, $urandom, $urandom}), 1'b0, w);
        expect_beat("latch3", 5'b01000, 3, 256'hE3, 1'b0);
        send(256'hE4, mk_user(5'b00000, {$urandom, $urandom, $urandom, $urandom}), 1'b1, w);
        expect_beat("latch4", 5'b01000, 3, 256'hE4, 1'b1);
        check("latch/drop", 256'(drop_count), 256'hFFFF_FFFF);

        // Reset during beat 2 of a 4-beat packet to port 0.
        send(256'hF1, mk_user(5'b00001, 128'h0), 1'b0, w);
        expect_beat("rstmid1", 5'b00001, 0, 256'hF1, 1'b0);
        oready[0]     = 1'b0;
        s_axis_tdata  = 256'hF2;
        s_axis_tuser  = mk_user(5'b00001, 128'h0);
        s_axis_tlast  = 1'b0;
        s_axis_tvalid = 1'b1;
        #2;
        axi_resetn = 1'b0;
        #1;
        check("rstmid/valid", 256'(ovalid), 256'd0);
        check("rstmid/tready", 256'(s_axis_tready), 256'd0);
        check("rstmid/drop", 256'(drop_count), 256'd0);
        @(negedge axi_aclk);
        s_axis_tvalid = 1'b0;
        oready[0]     = 1'b1;
        axi_resetn    = 1'b1;
        send(256'hF9, mk_user(5'b00100, 128'h0), 1'b1, w);
        expect_beat("rstmid/head", 5'b00100, 2, 256'hF9, 1'b1);
        @(negedge axi_aclk);
        check("rstmid/idle", 256'(ovalid), 256'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
